// File: rtl/collision_checker.sv
// collision_checker
//   Pipelined tetromino move checker. A start pulse latches the active
//   piece and one candidate move (down/left/right/rotate cw). It then
//   issues one board-RAM read per piece cell and bounds-checks each cell.
//   After that it registers the accepted anchor/rotation, a collision flag
//   and a lock request, together with a one-cycle done strobe.
//
// Ports
//   clk, resetn          : clock, asynchronous active-low reset
//   start, cmd           : request strobe and move (00 dn, 01 lt, 10 rt, 11 rot)
//   x_anchor, y_anchor   : current anchor
//   block, rot           : piece type and current rotation
//   lut_block, lut_rot   : shape LUT selects (follow inputs in IDLE)
//   lut_dx, lut_dy       : per-cell 2-bit offsets from the LUT, cell k at [2k+1:2k]
//   ram_addr, ram_q      : board RAM read port (one-cycle read latency)
//   busy, done           : check in progress / one-cycle result strobe
//   collision, lock      : move illegal / down move blocked, piece must lock
//   x_out, y_out, rot_out: accepted anchor and rotation
module collision_checker #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 24,
  parameter int X_W     = 5,
  parameter int Y_W     = 6,
  parameter int ADDR_W  = 8,
  parameter int CELL_W  = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [1:0]        cmd,
  input  logic [X_W-1:0]    x_anchor,
  input  logic [Y_W-1:0]    y_anchor,
  input  logic [2:0]        block,
  input  logic [1:0]        rot,
  output logic [2:0]        lut_block,
  output logic [1:0]        lut_rot,
  input  logic [7:0]        lut_dx,
  input  logic [7:0]        lut_dy,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [CELL_W-1:0] ram_q,
  output logic              busy,
  output logic              done,
  output logic              collision,
  output logic              lock,
  output logic [X_W-1:0]    x_out,
  output logic [Y_W-1:0]    y_out,
  output logic [1:0]        rot_out
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  localparam logic [1:0] CMD_DOWN  = 2'b00;
  localparam logic [1:0] CMD_LEFT  = 2'b01;
  localparam logic [1:0] CMD_RIGHT = 2'b10;
  localparam logic [1:0] CMD_ROT   = 2'b11;
  localparam logic [X_W:0] X_ONE   = (X_W+1)'(1);
  localparam logic [Y_W:0] Y_ONE   = (Y_W+1)'(1);
  localparam logic [X_W:0] X_LIM   = (X_W+1)'(BOARD_W);
  localparam logic [Y_W:0] Y_LIM   = (Y_W+1)'(BOARD_H);

  // Row-major board address of an in-bounds cell, truncated to the RAM width.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [X_W:0] cx, input logic [Y_W:0] cy);
    logic [31:0] full;
    full = 32'(cy) * 32'(BOARD_W) + 32'(cx);
    return full[ADDR_W-1:0];
  endfunction

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [2:0]        block_q, block_d;
  logic [1:0]        rot_q, rot_d;
  logic [X_W:0]      tx_q, tx_d;
  logic [Y_W:0]      ty_q, ty_d;
  logic [1:0]        trot_q, trot_d;
  logic              neg_q, neg_d;       // left move from x=0: every cell off the board
  logic              acc_q, acc_d;       // collision accumulated over returned cells
  logic              oob_prev_q, oob_prev_d; // OOB flag of the cell whose data returns now
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              col_q, col_d;
  logic              lock_q, lock_d;
  logic [X_W-1:0]    xo_q, xo_d;
  logic [Y_W-1:0]    yo_q, yo_d;
  logic [1:0]        ro_q, ro_d;

  logic [1:0]        dx_s, dy_s;
  logic [X_W:0]      cx_s;
  logic [Y_W:0]      cy_s;
  logic              cell_oob_s;
  logic              hit_s;
  logic              accept_s;

  assign dx_s       = lut_dx[{idx_q, 1'b0} +: 2];
  assign dy_s       = lut_dy[{idx_q, 1'b0} +: 2];
  assign cx_s       = tx_q + {{(X_W-1){1'b0}}, dx_s};
  assign cy_s       = ty_q + {{(Y_W-1){1'b0}}, dy_s};
  assign cell_oob_s = neg_q | (cx_s >= X_LIM) | (cy_s >= Y_LIM);
  // Data for an OOB cell is don't-care: its flag alone decides.
  assign hit_s      = oob_prev_q | (ram_q != {CELL_W{1'b0}});
  assign accept_s   = start & ((state_q == S_IDLE) | (state_q == S_DONE));

  assign busy      = busy_q;
  assign done      = done_q;
  assign collision = col_q;
  assign lock      = lock_q;
  assign x_out     = xo_q;
  assign y_out     = yo_q;
  assign rot_out   = ro_q;

  // Shape LUT selects: live inputs while idle, latched target otherwise.
  always_comb begin
    lut_block = block_q;
    lut_rot   = trot_q;
    if (state_q == S_IDLE) begin
      lut_block = block;
      lut_rot   = rot;
    end else begin
      lut_block = block_q;
      lut_rot   = trot_q;
    end
  end

  // Board read address for the cell currently being issued.
  always_comb begin
    ram_addr = {ADDR_W{1'b0}};
    if ((state_q == S_ISSUE) && !cell_oob_s) begin
      ram_addr = cell_addr(cx_s, cy_s);
    end else begin
      ram_addr = {ADDR_W{1'b0}};
    end
  end

  // Next-state, request latch, accumulation and result logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cmd_d      = cmd_q;
    x_d        = x_q;
    y_d        = y_q;
    block_d    = block_q;
    rot_d      = rot_q;
    tx_d       = tx_q;
    ty_d       = ty_q;
    trot_d     = trot_q;
    neg_d      = neg_q;
    acc_d      = acc_q;
    oob_prev_d = oob_prev_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    col_d      = col_q;
    lock_d     = lock_q;
    xo_d       = xo_q;
    yo_d       = yo_q;
    ro_d       = ro_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          state_d    = S_ISSUE;
          idx_d      = 2'd0;
          busy_d     = 1'b1;
          acc_d      = 1'b0;
          oob_prev_d = 1'b0;
          cmd_d      = cmd;
          x_d        = x_anchor;
          y_d        = y_anchor;
          block_d    = block;
          rot_d      = rot;
          tx_d       = {1'b0, x_anchor};
          ty_d       = {1'b0, y_anchor};
          trot_d     = rot;
          neg_d      = 1'b0;
          case (cmd)
            CMD_DOWN:  ty_d = {1'b0, y_anchor} + Y_ONE;
            CMD_LEFT: begin
              tx_d  = {1'b0, x_anchor} - X_ONE;
              neg_d = (x_anchor == {X_W{1'b0}});
            end
            CMD_RIGHT: tx_d = {1'b0, x_anchor} + X_ONE;
            CMD_ROT:   trot_d = rot + 2'd1;
            default:   trot_d = rot;
          endcase
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_ISSUE: begin
        oob_prev_d = cell_oob_s;
        // ram_q holds the previous cell's word from index 1 onwards.
        if (idx_q != 2'd0) begin
          acc_d = acc_q | hit_s;
        end else begin
          acc_d = acc_q;
        end
        if (idx_q == 2'd3) begin
          state_d = S_DRAIN;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        col_d   = acc_q | hit_s;
        lock_d  = (acc_q | hit_s) & (cmd_q == CMD_DOWN);
        if (acc_q | hit_s) begin
          xo_d = x_q;
          yo_d = y_q;
          ro_d = rot_q;
        end else begin
          xo_d = tx_q[X_W-1:0];
          yo_d = ty_q[Y_W-1:0];
          ro_d = trot_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      idx_q      <= 2'd0;
      cmd_q      <= 2'd0;
      x_q        <= {X_W{1'b0}};
      y_q        <= {Y_W{1'b0}};
      block_q    <= 3'd0;
      rot_q      <= 2'd0;
      tx_q       <= {(X_W+1){1'b0}};
      ty_q       <= {(Y_W+1){1'b0}};
      trot_q     <= 2'd0;
      neg_q      <= 1'b0;
      acc_q      <= 1'b0;
      oob_prev_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      col_q      <= 1'b0;
      lock_q     <= 1'b0;
      xo_q       <= {X_W{1'b0}};
      yo_q       <= {Y_W{1'b0}};
      ro_q       <= 2'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cmd_q      <= cmd_d;
      x_q        <= x_d;
      y_q        <= y_d;
      block_q    <= block_d;
      rot_q      <= rot_d;
      tx_q       <= tx_d;
      ty_q       <= ty_d;
      trot_q     <= trot_d;
      neg_q      <= neg_d;
      acc_q      <= acc_d;
      oob_prev_q <= oob_prev_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      col_q      <= col_d;
      lock_q     <= lock_d;
      xo_q       <= xo_d;
      yo_q       <= yo_d;
      ro_q       <= ro_d;
    end
  end

endmodule

// File: tb/tb_collision_checker.sv
// tb_collision_checker
//   Directed bench for collision_checker on a 10x24 board. The shape LUT
//   is an O piece for every block/rotation and the board RAM is a
//   one-cycle synchronous memory. Table vectors carry hand-computed
//   addresses and results. Hand sequences cover an ignored mid-check
//   start, back-to-back starts and an asynchronous reset mid-check.
module tb_collision_checker;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [1:0] cmd;
  logic [4:0] x_anchor;
  logic [5:0] y_anchor;
  logic [2:0] block;
  logic [1:0] rot;
  logic [2:0] lut_block;
  logic [1:0] lut_rot;
  logic [7:0] lut_dx;
  logic [7:0] lut_dy;
  logic [7:0] ram_addr;
  logic [5:0] ram_q;
  logic       busy, done, collision, lock;
  logic [4:0] x_out;
  logic [5:0] y_out;
  logic [1:0] rot_out;

  int checks   = 0;
  int failures = 0;

  logic [5:0] mem [0:255];

  typedef struct {
    int cmd; int x; int y; int blk; int rot; int occ;
    int a0; int a1; int a2; int a3;
    int col; int lck; int ex; int ey; int erot; int elrot;
  } vec_t;

  vec_t vecs[12];

  collision_checker dut (
    .clk(clk), .resetn(resetn), .start(start), .cmd(cmd),
    .x_anchor(x_anchor), .y_anchor(y_anchor), .block(block), .rot(rot),
    .lut_block(lut_block), .lut_rot(lut_rot), .lut_dx(lut_dx), .lut_dy(lut_dy),
    .ram_addr(ram_addr), .ram_q(ram_q), .busy(busy), .done(done),
    .collision(collision), .lock(lock), .x_out(x_out), .y_out(y_out),
    .rot_out(rot_out)
  );

  always #5 clk = ~clk;

  // O piece: offsets (0,0),(1,0),(0,1),(1,1) in cell order 0..3
  assign lut_dx = 8'h44;
  assign lut_dy = 8'h50;

  always @(posedge clk) ram_q <= mem[ram_addr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 6'h00;
  endtask

  task automatic drive(input int c, input int x, input int y, input int b, input int r);
    cmd = 2'(c); x_anchor = 5'(x); y_anchor = 6'(y); block = 3'(b); rot = 2'(r);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " collision"}, int'(collision), 0);
    chk({tag, " lock"}, int'(lock), 0);
    chk({tag, " x_out"}, int'(x_out), 0);
    chk({tag, " y_out"}, int'(y_out), 0);
    chk({tag, " rot_out"}, int'(rot_out), 0);
    chk({tag, " ram_addr"}, int'(ram_addr), 0);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int a[4];
    int ndone, first, lb, lr, bz, c, l, xo, yo, ro;
    ndone = 0; first = 0; lb = 0; lr = 0; bz = 0; c = 0; l = 0; xo = 0; yo = 0; ro = 0;
    clear_mem();
    if (v.occ >= 0) mem[v.occ] = 6'h05;
    @(negedge clk);
    start = 1'b1;
    drive(v.cmd, v.x, v.y, v.blk, v.rot);
    @(posedge clk);
    #1;
    start = 1'b0;
    // scramble the inputs: the check must run on latched values
    drive(v.cmd ^ 1, v.x ^ 5'h1f, v.y ^ 6'h2a, v.blk ^ 7, v.rot ^ 1);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n <= 4) a[n-1] = int'(ram_addr);
      if (n == 1) begin lb = int'(lut_block); lr = int'(lut_rot); bz = int'(busy); end
      if (done) begin
        ndone++;
        if (first == 0) begin
          first = n; c = int'(collision); l = int'(lock);
          xo = int'(x_out); yo = int'(y_out); ro = int'(rot_out);
        end
      end
    end
    chk({tag, " addr0"}, a[0], v.a0);
    chk({tag, " addr1"}, a[1], v.a1);
    chk({tag, " addr2"}, a[2], v.a2);
    chk({tag, " addr3"}, a[3], v.a3);
    chk({tag, " lut_block"}, lb, v.blk);
    chk({tag, " lut_rot"}, lr, v.elrot);
    chk({tag, " busy_in_check"}, bz, 1);
    chk({tag, " done_cycle"}, first, 6);
    chk({tag, " done_count"}, ndone, 1);
    chk({tag, " collision"}, c, v.col);
    chk({tag, " lock"}, l, v.lck);
    chk({tag, " x_out"}, xo, v.ex);
    chk({tag, " y_out"}, yo, v.ey);
    chk({tag, " rot_out"}, ro, v.erot);
    chk({tag, " busy_after"}, int'(busy), 0);
    chk({tag, " x_out_held"}, int'(x_out), v.ex);
    chk({tag, " collision_held"}, int'(collision), v.col);
  endtask

  initial begin
    int ndone, first;
    clear_mem();
    resetn = 1'b0;
    start  = 1'b0;
    drive(0, 0, 0, 3, 2);

    //            cmd x  y  blk rot occ  a0   a1   a2   a3  col lck ex ey erot elrot
    vecs[0]  = '{0, 4, 0, 0, 0, -1, 14,  15,  24,  25,  0, 0, 4, 1,  0, 0};
    vecs[1]  = '{0, 4, 0, 0, 0, 15, 14,  15,  24,  25,  1, 1, 4, 0,  0, 0};
    vecs[2]  = '{1, 0, 5, 0, 0, -1, 0,   0,   0,   0,   1, 0, 0, 5,  0, 0};
    vecs[3]  = '{2, 8, 5, 0, 0, -1, 59,  0,   69,  0,   1, 0, 8, 5,  0, 0};
    vecs[4]  = '{0, 4, 22, 0, 0, -1, 234, 235, 0,   0,   1, 1, 4, 22, 0, 0};
    vecs[5]  = '{3, 2, 3, 0, 3, -1, 32,  33,  42,  43,  0, 0, 2, 3,  0, 0};
    vecs[6]  = '{1, 5, 10, 0, 1, -1, 104, 105, 114, 115, 0, 0, 4, 10, 1, 1};
    vecs[7]  = '{2, 3, 7, 4, 2, 85, 74,  75,  84,  85,  1, 0, 3, 7,  2, 2};
    vecs[8]  = '{0, 7, 2, 5, 1, 99, 37,  38,  47,  48,  0, 0, 7, 3,  1, 1};
    vecs[9]  = '{1, 1, 0, 6, 0, -1, 0,   1,   10,  11,  0, 0, 0, 0,  0, 0};
    vecs[10] = '{2, 7, 0, 1, 3, -1, 8,   9,   18,  19,  0, 0, 8, 0,  3, 3};
    vecs[11] = '{3, 2, 3, 2, 1, 42, 32,  33,  42,  43,  1, 0, 2, 3,  1, 2};

    // reset state and idle LUT passthrough
    @(negedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    chk("idle lut_block", int'(lut_block), 3);
    chk("idle lut_rot", int'(lut_rot), 2);
    resetn = 1'b1;

    for (int i = 0; i < 12; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // start pulse at E2 of a rotate check is ignored
    clear_mem();
    ndone = 0; first = 0;
    @(negedge clk);
    start = 1'b1;
    drive(3, 2, 3, 0, 3);
    @(posedge clk); #1 start = 1'b0;      // E0
    @(posedge clk); #1 start = 1'b1;      // after E1
    @(posedge clk); #1 start = 1'b0;      // E2 sampled it
    for (int n = 3; n <= 16; n++) begin
      @(negedge clk);
      if (n == 3) chk("ign lut_rot", int'(lut_rot), 0);
      if (done) begin
        ndone++;
        if (first == 0) first = n;
      end
    end
    chk("ign done_cycle", first, 6);
    chk("ign done_count", ndone, 1);
    chk("ign rot_out", int'(rot_out), 0);
    chk("ign collision", int'(collision), 0);

    // back-to-back: start held in DONE begins the next check at once
    first = 0;
    @(negedge clk);
    start = 1'b1;
    drive(0, 4, 0, 0, 0);
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= 10 && first == 0; n++) begin
      @(negedge clk);
      if (done) first = n;
    end
    chk("b2b first done", first, 6);
    chk("b2b first y_out", int'(y_out), 1);
    start = 1'b1;
    drive(2, 7, 0, 0, 1);
    @(posedge clk); #1 start = 1'b0;      // E6 of first = E0 of second
    first = 0; ndone = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) chk("b2b busy", int'(busy), 1);
      if (done) begin
        ndone++;
        if (first == 0) first = n;
      end
    end
    chk("b2b second done", first, 6);
    chk("b2b second count", ndone, 1);
    chk("b2b second x_out", int'(x_out), 8);
    chk("b2b second rot_out", int'(rot_out), 1);

    // asynchronous reset at E3 of a check after a nonzero result
    run_vec("pre_rst", vecs[11]);
    @(negedge clk);
    start = 1'b1;
    drive(0, 4, 0, 0, 0);
    @(posedge clk); #1 start = 1'b0;      // E0
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);                       // E3
    #1 resetn = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    ndone = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    resetn = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("rst no done", ndone, 0);
    chk("rst busy idle", int'(busy), 0);
    run_vec("post_rst", vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
